mccpu_ctrl_fsm: RTL

Multi-cycle control unit for the MCCPU datapath. It sequences each instruction through the fetch, decode, execute, memory and writeback steps. Each cycle it drives every datapath mux select (mux2 and mux4 instances) and every architectural write enable. It sits between the IR opcode/funct fields plus the ALU zero flag on one side, and the PC, IR, memory, register file and ALU on the other.

---
 rtl/mccpu_ctrl_fsm_pkg.sv | 74 +++++++
 rtl/mccpu_ctrl_fsm_alu_dec.sv | 28 ++
 rtl/mccpu_ctrl_fsm.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mccpu_ctrl_fsm_pkg.sv
// rtl/mccpu_ctrl_fsm_pkg.sv - shared state, opcode, funct, ALU and mux select codes
package mccpu_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MA     = 4'd2,
        S_MR     = 4'd3,
        S_MWB    = 4'd4,
        S_MW     = 4'd5,
        S_EXE    = 4'd6,
        S_AWB    = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU operations
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_PASSB = 4'd6;

    // Next-PC mux
    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // Register write-data mux
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MDR = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // Destination register mux
    localparam logic [1:0] GPR_RT = 2'b00;
    localparam logic [1:0] GPR_RD = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;

    // ALU B operand mux
    localparam logic [1:0] ASB_RT    = 2'b00;
    localparam logic [1:0] ASB_FOUR  = 2'b01;
    localparam logic [1:0] ASB_IMM   = 2'b10;
    localparam logic [1:0] ASB_IMMSH = 2'b11;

    // Immediate extender
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

endpackage

// File: rtl/mccpu_ctrl_fsm_alu_dec.sv
// rtl/mccpu_ctrl_fsm_alu_dec.sv - R-type funct to ALU operation decode
module mccpu_ctrl_fsm_alu_dec
    import mccpu_ctrl_fsm_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal,
    output logic       is_jr
);

    // Map funct to ALU op; unknown functs are flagged so DECODE can drop them
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        is_jr  = 1'b0;
        case (funct)
            FN_ADDU: alu_op = ALU_ADD;
            FN_SUBU: alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL:  alu_op = ALU_SLL;
            FN_JR:   is_jr  = 1'b1;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mccpu_ctrl_fsm.sv
// rtl/mccpu_ctrl_fsm.sv - multi-cycle MCCPU control state machine
module mccpu_ctrl_fsm
    import mccpu_ctrl_fsm_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_we,
    output logic               ir_we,
    output logic               mem_we,
    output logic               rf_we,
    output logic               iord,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         gprsel,
    output logic [1:0]         wdsel,
    output logic [1:0]         npc_op,
    output logic [1:0]         ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [STATE_W-1:0] state
);

    state_e     r_state;
    state_e     w_next;
    logic [3:0] w_alu_op;
    logic [3:0] w_dec_alu_op;
    logic       w_dec_legal;
    logic       w_dec_is_jr;
    logic       w_is_rtype;

    assign w_is_rtype = (op == OP_RTYPE);

    mccpu_ctrl_fsm_alu_dec u_alu_dec (
        .funct  (funct),
        .alu_op (w_dec_alu_op),
        .legal  (w_dec_legal),
        .is_jr  (w_dec_is_jr)
    );

    // State register; reset abandons whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath controls, all forced idle while reset is held
    always_comb begin
        w_next   = S_FETCH;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        mem_we   = 1'b0;
        rf_we    = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ASB_RT;
        gprsel   = GPR_RT;
        wdsel    = WD_ALU;
        npc_op   = NPC_PC4;
        ext_op   = EXT_ZERO;
        w_alu_op = ALU_ADD;

        case (r_state)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                alusrcb = ASB_FOUR;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= PC+4 + (sext(imm)<<2), ready if this is a branch
                alusrcb = ASB_IMMSH;
                ext_op  = EXT_SIGN;
                case (op)
                    OP_LW, OP_SW:            w_next = S_MA;
                    OP_ADDI, OP_ORI, OP_LUI: w_next = S_EXE;
                    OP_BEQ, OP_BNE:          w_next = S_BR;
                    OP_J, OP_JAL:            w_next = S_JMP;
                    OP_RTYPE: begin
                        if (!w_dec_legal) begin
                            w_next = S_FETCH;
                        end else if (w_dec_is_jr) begin
                            w_next = S_JMP;
                        end else begin
                            w_next = S_EXE;
                        end
                    end
                    default:                 w_next = S_FETCH;
                endcase
            end
            S_MA: begin
                alusrca = 1'b1;
                alusrcb = ASB_IMM;
                ext_op  = EXT_SIGN;
                if (op == OP_LW) begin
                    w_next = S_MR;
                end else if (op == OP_SW) begin
                    w_next = S_MW;
                end
            end
            S_MR: begin
                iord   = 1'b1;
                w_next = S_MWB;
            end
            S_MWB: begin
                rf_we  = 1'b1;
                gprsel = GPR_RT;
                wdsel  = WD_MDR;
            end
            S_MW: begin
                iord   = 1'b1;
                mem_we = 1'b1;
            end
            S_EXE: begin
                alusrca = 1'b1;
                w_next  = S_AWB;
                if (w_is_rtype) begin
                    alusrcb  = ASB_RT;
                    w_alu_op = w_dec_alu_op;
                end else begin
                    alusrcb = ASB_IMM;
                    case (op)
                        OP_ADDI: begin
                            ext_op   = EXT_SIGN;
                            w_alu_op = ALU_ADD;
                        end
                        OP_ORI: begin
                            ext_op   = EXT_ZERO;
                            w_alu_op = ALU_OR;
                        end
                        OP_LUI: begin
                            ext_op   = EXT_LUI;
                            w_alu_op = ALU_PASSB;
                        end
                        default: ;
                    endcase
                end
            end
            S_AWB: begin
                rf_we  = 1'b1;
                wdsel  = WD_ALU;
                gprsel = w_is_rtype ? GPR_RD : GPR_RT;
            end
            S_BR: begin
                alusrca  = 1'b1;
                alusrcb  = ASB_RT;
                w_alu_op = ALU_SUB;
                npc_op   = NPC_BR;
                if (op == OP_BEQ) begin
                    pc_we = zero;
                end else if (op == OP_BNE) begin
                    pc_we = ~zero;
                end
            end
            S_JMP: begin
                pc_we  = 1'b1;
                npc_op = w_is_rtype ? NPC_JR : NPC_JMP;
                if (op == OP_JAL) begin
                    rf_we  = 1'b1;
                    gprsel = GPR_RA;
                    wdsel  = WD_PC;
                end
            end
            default: w_next = S_FETCH;
        endcase

        if (rst) begin
            pc_we    = 1'b0;
            ir_we    = 1'b0;
            mem_we   = 1'b0;
            rf_we    = 1'b0;
            iord     = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = ASB_RT;
            gprsel   = GPR_RT;
            wdsel    = WD_ALU;
            npc_op   = NPC_PC4;
            ext_op   = EXT_ZERO;
            w_alu_op = ALU_ADD;
        end
    end

    assign alu_op = ALUOP_W'(w_alu_op);
    assign state  = STATE_W'(r_state);

endmodule
